dac_serializer_param: RTL

- Parametrised serial DAC front-end that takes a parallel sample plus control bits over a valid/ready handshake and shifts out one framed word (sync low, data, SPI-style clock).
- Owns its own bit and clock-divide counters, so no upstream delay counter is needed.
- Sits between the waveform generator (ramp/DDS sample source) and the DAC pins; one instance per DAC device.

---
 rtl/dac_serializer_param_pkg.sv | 27 ++
 rtl/dac_serializer_param_if.sv | 30 +++
 rtl/dac_serializer_param_sclk_divider.sv | 46 ++++
 rtl/dac_serializer_param.sv | 138 +++++++++++++
 4 files changed

// File: rtl/dac_serializer_param_pkg.sv
// Shared types and helpers for the serial DAC front-end.
//   state_e : serializer FSM states
//   FRAME_W : frame width of the default configuration (CTRL_W=2, DATA_W=16)
//   clog2   : counter width helper, never returns less than 1
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  localparam int unsigned FRAME_W = 18;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while (w < 32 && (32'd1 << w) < value) w++;
    return w;
  endfunction

  function automatic int unsigned frame_w(input int unsigned ctrl_w,
                                          input int unsigned data_w);
    return ctrl_w + data_w;
  endfunction

endpackage

// File: rtl/dac_serializer_param_if.sv
// Upstream sample handshake plus DAC pin bundle for dac_serializer_param.
//   master : sample source side (drives din/din_ctrl/din_valid)
//   slave  : serializer side (drives din_ready and the DAC pins/status)
// din_ctrl is at least one bit wide even when no control bits are sent.
interface dac_serializer_param_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CTRL_W = 2
);
  localparam int unsigned CTRL_PW = (CTRL_W > 0) ? CTRL_W : 1;

  logic [DATA_W-1:0]  din;
  logic [CTRL_PW-1:0] din_ctrl;
  logic               din_valid;
  logic               din_ready;
  logic               dac_in;
  logic               sync;
  logic               dac_sclk;
  logic               busy;
  logic               frame_done;

  modport master (
    output din, din_ctrl, din_valid,
    input  din_ready, dac_in, sync, dac_sclk, busy, frame_done
  );

  modport slave (
    input  din, din_ctrl, din_valid,
    output din_ready, dac_in, sync, dac_sclk, busy, frame_done
  );
endinterface

// File: rtl/dac_serializer_param_sclk_divider.sv
// Bit-period divider: counts 0..2*DIV-1 while enabled.
//   clk, rst_n : clock, async active-low reset
//   en         : advance the counter
//   clr        : hold the counter at zero (wins over en)
//   sclk_lvl   : serial clock level, low for the first DIV counts of a bit
//   bit_start  : first count of a bit period
//   bit_end    : last count of a bit period
module sclk_divider
  import dac_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic sclk_lvl,
  output logic bit_start,
  output logic bit_end
);
  localparam int unsigned PERIOD = 2 * DIV;
  localparam int unsigned CW     = clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

  assign sclk_lvl  = (div_cnt_q >= HALF);
  assign bit_start = en && (div_cnt_q == '0);
  assign bit_end   = en && (div_cnt_q == LAST);

endmodule

// File: rtl/dac_serializer_param.sv
// Serial DAC front-end: accepts {din_ctrl, din} over valid/ready and shifts
// one frame out with sync low, then holds sync high for GAP_BITS bit periods.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of dac_serializer_param_if
//                (din, din_ctrl, din_valid -> din_ready, dac_in, sync,
//                 dac_sclk, busy, frame_done)
module dac_serializer_param
  import dac_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CTRL_W    = 2,
  parameter int unsigned DIV       = 1,
  parameter int unsigned GAP_BITS  = 1,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dac_serializer_param_if.slave   bus
);
  localparam int unsigned FW      = frame_w(CTRL_W, DATA_W);
  localparam int unsigned IDX_MAX = (FW > GAP_BITS) ? FW : GAP_BITS;
  localparam int unsigned IW      = clog2(IDX_MAX);
  localparam logic [IW-1:0] LAST_BIT = IW'(FW - 1);
  localparam logic [IW-1:0] LAST_GAP = IW'(GAP_BITS - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   bit_idx_q, bit_idx_d;
  logic [FW-1:0]   shreg_q, shreg_d;
  logic            frame_done_q, frame_done_d;

  logic [FW-1:0]     load_frame;
  logic [DATA_W-1:0] data_ord;
  logic              sclk_lvl;
  logic              bit_end;
  // dac_in is taken straight from the shift register MSB, which already
  // changes on the bit-period wrap, so the start strobe is not needed here.
  logic              bit_start_unused;

  // Bit order is fixed at load time so the shifter always sends MSB first;
  // ctrl and data are reversed independently and ctrl stays in front.
  always_comb begin
    data_ord = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      data_ord[i] = (LSB_FIRST != 0) ? bus.din[DATA_W-1-i] : bus.din[i];
    end
  end

  if (CTRL_W > 0) begin : g_ctrl
    logic [CTRL_W-1:0] ctrl_ord;
    always_comb begin
      ctrl_ord = '0;
      for (int unsigned i = 0; i < CTRL_W; i++) begin
        ctrl_ord[i] = (LSB_FIRST != 0) ? bus.din_ctrl[CTRL_W-1-i] : bus.din_ctrl[i];
      end
    end
    assign load_frame = {ctrl_ord, data_ord};
  end else begin : g_no_ctrl
    logic unused_ctrl;
    assign unused_ctrl = ^bus.din_ctrl;
    assign load_frame  = data_ord;
  end

  sclk_divider #(
    .DIV (DIV)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_q != IDLE),
    .clr       (state_q == IDLE),
    .sclk_lvl  (sclk_lvl),
    .bit_start (bit_start_unused),
    .bit_end   (bit_end)
  );

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        bit_idx_d = '0;
        if (bus.din_valid) begin
          state_d = SHIFT;
          shreg_d = load_frame;
        end
      end
      SHIFT: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d      = GAP;
            bit_idx_d    = '0;
            shreg_d      = '0;
            frame_done_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shreg_d   = shreg_q << 1;
          end
        end
      end
      GAP: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_GAP) begin
            state_d   = IDLE;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pin outputs decode the registered state, so an async reset returns them
  // to idle levels immediately.
  assign bus.din_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.sync       = (state_q != SHIFT);
  assign bus.dac_sclk   = (state_q == SHIFT) && sclk_lvl;
  assign bus.dac_in     = (state_q == SHIFT) && shreg_q[FW-1];
  assign bus.frame_done = frame_done_q;

endmodule
